// File: rtl/sna_pkg.sv
// Shared types and helpers for the shared-net arbiter: FSM state encoding,
// the default owner index width and the round-robin pointer increment.
package sna_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int OWNER_W     = $clog2(NUM_REQ_DEF);

  // Next round-robin pointer: one past ptr, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned ptr,
                                          input int unsigned n = NUM_REQ_DEF);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/sna_rr_pick.sv
// Combinational round-robin picker: the first set request at or above ptr,
// wrapping around, as a one-hot grant, an encoded index and an any flag.
module sna_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int          k;
  logic [IW-1:0] kidx;

  // NOTE: every output gets a default before the search loop; without it an
  // empty request vector would leave them unassigned and infer latches.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    kidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      kidx = IW'(k);
      if (!any && req[kidx]) begin
        any         = 1'b1;
        grant[kidx] = 1'b1;
        idx         = kidx;
      end
    end
  end

endmodule

// File: rtl/shared_net_arbiter.sv
// Round-robin owner of one broadcast net feeding a near and a far load group.
// Define SNA_TIMEOUT_EN to abort transfers left unacknowledged for TIMEOUT_CYC cycles.
module shared_net_arbiter
  import sna_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      bus_valid,
  output logic [DATA_W-1:0]         bus_data,
  output logic [$clog2(NUM_REQ)-1:0] bus_owner,
  input  logic                      near_ack,
  input  logic                      far_ack,
  output logic                      done,
  output logic                      err_timeout
);

  localparam int IW = $clog2(NUM_REQ);

  state_t            state, state_nxt;
  logic [IW-1:0]     rr_ptr;
  logic [IW-1:0]     pick_idx;
  logic [NUM_REQ-1:0] pick_grant;
  logic              pick_any;
  logic              near_seen, far_seen;
  logic              complete, abort;

  sna_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IW     (IW)
  ) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr),
    .grant(pick_grant),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // An ack arriving in the same cycle counts as if it were already latched.
  assign complete = (state == BCAST) && (near_seen || near_ack) && (far_seen || far_ack);

`ifdef SNA_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [CW-1:0] cnt;

  assign abort = (state == BCAST) && !complete && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst || state == IDLE) cnt <= '0;
    else if (!complete)       cnt <= cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC > 0);
  assign abort = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = BCAST;
      BCAST:   if (complete || abort) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Pulses are held low while reset forces the FSM back to IDLE.
  always_comb begin
    bus_valid   = (state == BCAST);
    req_ready   = '0;
    done        = 1'b0;
    err_timeout = 1'b0;
    if (!rst) begin
      if (state == IDLE) req_ready = pick_grant;
      done        = complete;
      err_timeout = abort;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_data  <= '0;
      bus_owner <= '0;
      rr_ptr    <= '0;
      near_seen <= 1'b0;
      far_seen  <= 1'b0;
    end else if (state == IDLE) begin
      near_seen <= 1'b0;
      far_seen  <= 1'b0;
      if (pick_any) begin
        bus_data  <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
        bus_owner <= pick_idx;
      end
    end else begin
      near_seen <= near_seen | near_ack;
      far_seen  <= far_seen | far_ack;
      if (complete || abort) rr_ptr <= IW'(rr_next(int'(bus_owner), NUM_REQ));
    end
  end

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Self-checking bench for shared_net_arbiter: directed scenarios then random
// traffic, all compared cycle by cycle against a transaction-level model.
module tb_shared_net_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             bus_valid;
  logic [W-1:0]     bus_data;
  logic [1:0]       bus_owner;
  logic             near_ack, far_ack;
  logic             done, err_timeout;

  always #5 clk = ~clk;

  shared_net_arbiter #(
    .NUM_REQ    (N),
    .DATA_W     (W),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .bus_valid  (bus_valid),
    .bus_data   (bus_data),
    .bus_owner  (bus_owner),
    .near_ack   (near_ack),
    .far_ack    (far_ack),
    .done       (done),
    .err_timeout(err_timeout)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Transaction-level model: is a transfer on the net, who owns it, what it
  // carries, which groups have answered, and how long it has been out.
  bit         m_busy;
  int         m_owner;
  logic [W-1:0] m_data;
  bit         m_ns, m_fs;
  int         m_ptr;
  int         m_age;

  logic [N-1:0] o_ready;
  logic         o_valid, o_done, o_err;
  logic [W-1:0] o_data;
  logic [1:0]   o_owner;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] rv, input int ptr);
    for (int i = 0; i < N; i++)
      if (rv[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_data = '0; m_ns = 0; m_fs = 0; m_ptr = 0; m_age = 0;
  endtask

  // One clock cycle: drive inputs, compare every output at the falling edge,
  // then advance the model across the rising edge.
  task automatic cyc(input bit r, input logic [N-1:0] rv, input bit na, input bit fa);
    logic [N-1:0] e_ready;
    bit e_done, e_err, comp, tmo;
    int w;
    rst = r; req_valid = rv; near_ack = na; far_ack = fa;
    e_ready = '0; e_done = 0; e_err = 0; comp = 0; tmo = 0; w = -1;
    if (!m_busy) w = pick(rv, m_ptr);
    if (!r) begin
      if (!m_busy) begin
        if (w >= 0) e_ready[w] = 1'b1;
      end else begin
        comp = (m_ns || na) && (m_fs || fa);
`ifdef SNA_TIMEOUT_EN
        tmo = !comp && (m_age == TO);
`endif
        e_done = comp;
        e_err  = tmo;
      end
    end
    @(negedge clk);
    o_ready = req_ready; o_valid = bus_valid; o_data = bus_data;
    o_owner = bus_owner; o_done = done; o_err = err_timeout;
    check("req_ready",   32'(o_ready), 32'(e_ready));
    check("bus_valid",   32'(o_valid), 32'(m_busy));
    check("bus_data",    32'(o_data),  32'(m_data));
    check("bus_owner",   32'(o_owner), 32'(m_owner));
    check("done",        32'(o_done),  32'(e_done));
    check("err_timeout", 32'(o_err),   32'(e_err));
    @(posedge clk);
    if (r) model_reset();
    else if (!m_busy) begin
      if (w >= 0) begin
        m_busy = 1; m_owner = w; m_data = req_data[w*W +: W];
        m_ns = 0; m_fs = 0; m_age = 1;
      end
    end else if (comp || tmo) begin
      m_busy = 0;
      m_ptr  = (m_owner + 1) % N;
    end else begin
      m_ns = m_ns || na; m_fs = m_fs || fa; m_age++;
    end
    #1;
  endtask

  initial begin
    logic [1:0] owners[$];
    int err_cycle;

    rst = 1'b1; req_valid = '0; req_data = '0; near_ack = 0; far_ack = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state.
    cyc(1, '0, 0, 0);
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_owner", 32'(o_owner), 32'd0);

    // Single request from requester 0, then acks at BCAST cycles 2 and 5.
    req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    cyc(0, 4'b0001, 0, 0);
    check("t1_ready", 32'(o_ready), 32'h1);
    cyc(0, 4'b0000, 0, 0);
    check("t1_valid", 32'(o_valid), 32'd1);
    check("t1_data",  32'(o_data),  32'hA5);
    check("t1_owner", 32'(o_owner), 32'd0);
    cyc(0, 4'b0000, 1, 0);
    check("t2_c2_done", 32'(o_done), 32'd0);
    cyc(0, 4'b0000, 0, 0);
    cyc(0, 4'b0000, 0, 0);
    check("t2_c4_done", 32'(o_done), 32'd0);
    cyc(0, 4'b0000, 0, 1);
    check("t2_c5_done", 32'(o_done), 32'd1);
    cyc(0, 4'b0000, 0, 0);
    check("t2_c6_valid", 32'(o_valid), 32'd0);

    // All requesters held valid with immediate acks: strict rotation.
    cyc(1, '0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(0, 4'b1111, 1, 1);
      if (o_valid) owners.push_back(o_owner);
    end
    check("t3_count", 32'(owners.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("t3_owner", 32'(owners[i]), 32'(i % N));

    // Both acks in the first BCAST cycle; acks seen in IDLE must not carry over.
    cyc(0, 4'b0010, 0, 0);
    cyc(0, 4'b0000, 1, 1);
    check("t4_done_first", 32'(o_done), 32'd1);
    cyc(0, 4'b0100, 1, 1);
    check("t4_idle_ready", 32'(o_ready), 32'b0100);
    cyc(0, 4'b0000, 0, 0);
    check("t4_no_carry", 32'(o_done), 32'd0);
    cyc(0, 4'b0000, 1, 1);

    // Reset during a transfer owned by requester 2.
    cyc(1, '0, 0, 0);
    cyc(0, 4'b0100, 0, 0);
    cyc(0, 4'b1010, 0, 0);
    check("t5_owner2", 32'(o_owner), 32'd2);
    cyc(1, 4'b1010, 0, 0);
    cyc(0, 4'b1010, 0, 0);
    check("t5_valid0", 32'(o_valid), 32'd0);
    check("t5_data0",  32'(o_data),  32'd0);
    check("t5_owner0", 32'(o_owner), 32'd0);
    check("t5_grant",  32'(o_ready), 32'b0010);
    cyc(0, 4'b0000, 1, 1);

`ifdef SNA_TIMEOUT_EN
    // Far group never answers: abort in the 8th BCAST cycle, next grant skips owner 0.
    cyc(1, '0, 0, 0);
    cyc(0, 4'b0001, 0, 0);
    err_cycle = 0;
    for (int k = 1; k <= TO; k++) begin
      cyc(0, 4'b0000, 1, 0);
      if (o_err && err_cycle == 0) err_cycle = k;
      check("t6_done", 32'(o_done), 32'd0);
    end
    check("t6_err_cycle", 32'(err_cycle), 32'(TO));
    cyc(0, 4'b0011, 0, 0);
    check("t6_skip", 32'(o_ready), 32'b0010);
    cyc(0, 4'b0000, 1, 1);
`else
    err_cycle = 0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      req_data = {$urandom(), $urandom()};
      cyc(($urandom_range(0, 59) == 0), N'($urandom()),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
